// File: rtl/sobel_window_scheduler.sv
// Sobel sequencer: scans the image row-major, fetches each interior 3x3 window from b0 port 1
// and writes saturated |Gx|+|Gy| (0 on the border) to b1 port 1.
module sobel_window_scheduler #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 16,
    parameter int IMAGE_WIDTH  = 100,
    parameter int IMAGE_HEIGHT = 100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_run,
    output logic                  o_idle,
    output logic                  o_read,
    output logic                  o_write,
    output logic                  o_done,
    output logic                  b0_ce1,
    output logic                  b0_we1,
    output logic [ADDR_WIDTH-1:0] b0_addr1,
    input  logic [DATA_WIDTH-1:0] b0_q1,
    output logic                  b1_ce1,
    output logic                  b1_we1,
    output logic [ADDR_WIDTH-1:0] b1_addr1,
    output logic [DATA_WIDTH-1:0] b1_d1
);
    localparam int XW = $clog2(IMAGE_WIDTH);
    localparam int YW = $clog2(IMAGE_HEIGHT);
    localparam int SW = DATA_WIDTH + 3;
    localparam logic [ADDR_WIDTH-1:0] ROW      = ADDR_WIDTH'(IMAGE_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(IMAGE_WIDTH - 2);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_CALC, S_WRITE, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [ADDR_WIDTH-1:0] pix_q, pix_d;
    logic [3:0]            tap_q, tap_d;
    logic [DATA_WIDTH-1:0] p_q [9];
    logic                  b0_ce_q, b0_ce_d;
    logic [ADDR_WIDTH-1:0] b0_addr_q, b0_addr_d;
    logic                  b1_we_q, b1_we_d;
    logic [ADDR_WIDTH-1:0] b1_addr_q, b1_addr_d;
    logic [DATA_WIDTH-1:0] b1_data_q, b1_data_d;
    logic                  idle_q, read_q, write_q, done_q;

    logic signed [SW-1:0]  gx, gy;
    logic [SW-1:0]         ax, ay;
    logic [SW:0]           mag;
    logic [DATA_WIDTH-1:0] result;

    logic                  last_col, last_pix, next_border;
    logic [XW-1:0]         nx;
    logic [YW-1:0]         ny;

    function automatic logic signed [SW-1:0] ext(input logic [DATA_WIDTH-1:0] v);
        return $signed({3'b000, v});
    endfunction

    always_comb begin
        gx = (ext(p_q[2]) + (ext(p_q[5]) <<< 1) + ext(p_q[8]))
           - (ext(p_q[0]) + (ext(p_q[3]) <<< 1) + ext(p_q[6]));
        gy = (ext(p_q[6]) + (ext(p_q[7]) <<< 1) + ext(p_q[8]))
           - (ext(p_q[0]) + (ext(p_q[1]) <<< 1) + ext(p_q[2]));
        ax = gx[SW-1] ? $unsigned(-gx) : $unsigned(gx);
        ay = gy[SW-1] ? $unsigned(-gy) : $unsigned(gy);
        mag = {1'b0, ax} + {1'b0, ay};
        result = (|mag[SW:DATA_WIDTH]) ? '1 : mag[DATA_WIDTH-1:0];
    end

    // Pixel address is a running counter; the scan is contiguous so no y*W product is needed.
    always_comb begin
        last_col    = (x_q == XW'(IMAGE_WIDTH - 1));
        last_pix    = last_col && (y_q == YW'(IMAGE_HEIGHT - 1));
        nx          = last_col ? '0 : x_q + 1'b1;
        ny          = last_col ? y_q + 1'b1 : y_q;
        next_border = (nx == '0) || (nx == XW'(IMAGE_WIDTH - 1)) ||
                      (ny == '0) || (ny == YW'(IMAGE_HEIGHT - 1));
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        pix_d     = pix_q;
        tap_d     = tap_q;
        b0_ce_d   = 1'b0;
        b0_addr_d = b0_addr_q;
        b1_we_d   = 1'b0;
        b1_addr_d = b1_addr_q;
        b1_data_d = b1_data_q;
        case (state_q)
            S_IDLE: begin
                if (i_run) begin
                    state_d   = S_WRITE;
                    b1_we_d   = 1'b1;
                    b1_addr_d = pix_q;
                    b1_data_d = '0;
                end
            end
            S_READ: begin
                if (tap_q == 4'd9) begin
                    state_d = S_CALC;
                end else begin
                    tap_d = tap_q + 4'd1;
                    // Window walk: +1 along a row, +W-2 to jump to the next row's left tap.
                    if (tap_q < 4'd8) begin
                        b0_ce_d   = 1'b1;
                        b0_addr_d = b0_addr_q + ((tap_q == 4'd2 || tap_q == 4'd5) ? ROW_STEP : ADDR_WIDTH'(1));
                    end
                end
            end
            S_CALC: begin
                state_d   = S_WRITE;
                b1_we_d   = 1'b1;
                b1_addr_d = pix_q;
                b1_data_d = result;
            end
            S_WRITE: begin
                if (last_pix) begin
                    state_d = S_DONE;
                end else begin
                    x_d   = nx;
                    y_d   = ny;
                    pix_d = pix_q + 1'b1;
                    if (next_border) begin
                        state_d   = S_WRITE;
                        b1_we_d   = 1'b1;
                        b1_addr_d = pix_q + 1'b1;
                        b1_data_d = '0;
                    end else begin
                        state_d   = S_READ;
                        tap_d     = '0;
                        b0_ce_d   = 1'b1;
                        b0_addr_d = pix_q - ROW;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                x_d     = '0;
                y_d     = '0;
                pix_d   = '0;
                tap_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            pix_q     <= '0;
            tap_q     <= '0;
            p_q       <= '{default: '0};
            b0_ce_q   <= 1'b0;
            b0_addr_q <= '0;
            b1_we_q   <= 1'b0;
            b1_addr_q <= '0;
            b1_data_q <= '0;
            idle_q    <= 1'b1;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            pix_q     <= pix_d;
            tap_q     <= tap_d;
            b0_ce_q   <= b0_ce_d;
            b0_addr_q <= b0_addr_d;
            b1_we_q   <= b1_we_d;
            b1_addr_q <= b1_addr_d;
            b1_data_q <= b1_data_d;
            idle_q    <= (state_d == S_IDLE);
            read_q    <= (state_d == S_READ);
            write_q   <= (state_d == S_WRITE);
            done_q    <= (state_d == S_DONE);
            if (state_q == S_READ && tap_q != 4'd0)
                p_q[tap_q - 4'd1] <= b0_q1;
        end
    end

    assign o_idle   = idle_q;
    assign o_read   = read_q;
    assign o_write  = write_q;
    assign o_done   = done_q;
    assign b0_ce1   = b0_ce_q;
    assign b0_we1   = 1'b0;
    assign b0_addr1 = b0_addr_q;
    assign b1_ce1   = b1_we_q;
    assign b1_we1   = b1_we_q;
    assign b1_addr1 = b1_addr_q;
    assign b1_d1    = b1_data_q;

endmodule

// File: tb/tb_sobel_window_scheduler.sv
// Directed bench: a 3x3 and a 4x4 scheduler instance, each with behavioural BRAM models.
module tb_sobel_window_scheduler;
    localparam int DW = 8;
    localparam int AW = 8;

    logic clk;
    logic rst_n;
    logic run_a, run_b;
    logic clr;
    int   pat;
    int   n_checks, n_fail;

    logic          a_idle, a_read, a_write, a_done, a_b0_ce, a_b0_we, a_b1_ce, a_b1_we;
    logic [AW-1:0] a_b0_addr, a_b1_addr;
    logic [DW-1:0] a_b0_q, a_b1_d;
    logic          b_idle, b_read, b_write, b_done, b_b0_ce, b_b0_we, b_b1_ce, b_b1_we;
    logic [AW-1:0] b_b0_addr, b_b1_addr;
    logic [DW-1:0] b_b0_q, b_b1_d;

    logic [DW-1:0] a_img [9];
    logic [DW-1:0] a_out [9];
    logic [DW-1:0] b_img [16];
    logic [DW-1:0] b_out [16];
    int a_rd, a_wr, a_bad, b_rd, b_wr, b_bad, inv_bad;

    sobel_window_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMAGE_WIDTH(3), .IMAGE_HEIGHT(3)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_run(run_a),
        .o_idle(a_idle), .o_read(a_read), .o_write(a_write), .o_done(a_done),
        .b0_ce1(a_b0_ce), .b0_we1(a_b0_we), .b0_addr1(a_b0_addr), .b0_q1(a_b0_q),
        .b1_ce1(a_b1_ce), .b1_we1(a_b1_we), .b1_addr1(a_b1_addr), .b1_d1(a_b1_d)
    );

    sobel_window_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_run(run_b),
        .o_idle(b_idle), .o_read(b_read), .o_write(b_write), .o_done(b_done),
        .b0_ce1(b_b0_ce), .b0_we1(b_b0_we), .b0_addr1(b_b0_addr), .b0_q1(b_b0_q),
        .b1_ce1(b_b1_ce), .b1_we1(b_b1_we), .b1_addr1(b_b1_addr), .b1_d1(b_b1_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pix_val(input int p, input int x, input int y);
        case (p)
            0: return 8'd100;
            1: return (x == 0) ? 8'd0 : 8'd255;
            2: return 8'(10 * x);
            default: begin
                case (y * 4 + x)
                    0: return 8'd50;   1: return 8'd40;   2: return 8'd30;   3: return 8'd20;
                    4: return 8'd60;   5: return 8'd45;   6: return 8'd25;   7: return 8'd10;
                    8: return 8'd90;   9: return 8'd70;  10: return 8'd35;  11: return 8'd5;
                    12: return 8'd99; 13: return 8'd80;  14: return 8'd60;  15: return 8'd0;
                    default: return 8'd0;
                endcase
            end
        endcase
    endfunction

    // Hand-derived results for the 4x4 patterns (borders always 0).
    function automatic int exp_b(input int p, input int i);
        int x, y;
        x = i % 4;
        y = i / 4;
        if (x == 0 || x == 3 || y == 0 || y == 3) return 0;
        if (p == 2) return 80;
        case (i)
            5: return 250;
            6: return 180;
            default: return 255;
        endcase
    endfunction

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 9; i++) begin
                a_img[i] <= pix_val(pat, i % 3, i / 3);
                a_out[i] <= 8'hAA;
            end
            for (int i = 0; i < 16; i++) begin
                b_img[i] <= pix_val(pat, i % 4, i / 4);
                b_out[i] <= 8'hAA;
            end
            a_rd <= 0; a_wr <= 0; a_bad <= 0;
            b_rd <= 0; b_wr <= 0; b_bad <= 0;
        end else begin
            if (a_b0_ce) begin
                a_rd <= a_rd + 1;
                if (a_b0_addr < AW'(9)) a_b0_q <= a_img[a_b0_addr[3:0]];
                else a_bad <= a_bad + 1;
            end
            if (a_b1_ce && a_b1_we) begin
                a_wr <= a_wr + 1;
                if (a_b1_addr < AW'(9)) a_out[a_b1_addr[3:0]] <= a_b1_d;
                else a_bad <= a_bad + 1;
            end
            if (b_b0_ce) begin
                b_rd <= b_rd + 1;
                if (b_b0_addr < AW'(16)) b_b0_q <= b_img[b_b0_addr[3:0]];
                else b_bad <= b_bad + 1;
            end
            if (b_b1_ce && b_b1_we) begin
                b_wr <= b_wr + 1;
                if (b_b1_addr < AW'(16)) b_out[b_b1_addr[3:0]] <= b_b1_d;
                else b_bad <= b_bad + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (a_b0_we || b_b0_we || (a_b1_we != a_b1_ce) || (b_b1_we != b_b1_ce) ||
            ($countones({a_idle, a_read, a_write, a_done}) > 1) ||
            ($countones({b_idle, b_read, b_write, b_done}) > 1))
            inv_bad <= inv_bad + 1;
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic load(input int p);
        @(negedge clk);
        pat = p;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Starts a run so that the start edge is edge 0; returns the cycle in which o_done is seen.
    task automatic run_once(input bit sel_b, input bit pulse_read, output int done_cyc);
        bit pulsed;
        pulsed   = 1'b0;
        done_cyc = -1;
        @(negedge clk);
        if (sel_b) run_b = 1'b1; else run_a = 1'b1;
        @(negedge clk);
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            if (sel_b ? b_done : a_done) begin
                done_cyc = cyc;
                break;
            end
            if (sel_b) begin
                run_b = pulse_read && !pulsed && b_read;
                if (run_b) pulsed = 1'b1;
            end else begin
                run_a = 1'b0;
            end
            @(negedge clk);
        end
        run_a = 1'b0;
        run_b = 1'b0;
    endtask

    task automatic check_img_a(input string tag, input int p);
        for (int i = 0; i < 9; i++)
            check_eq($sformatf("%s_b1[%0d]", tag, i), 64'(a_out[i]), 64'((p == 1 && i == 4) ? 255 : 0));
    endtask

    task automatic check_img_b(input string tag, input int p);
        for (int i = 0; i < 16; i++)
            check_eq($sformatf("%s_b1[%0d]", tag, i), 64'(b_out[i]), 64'(exp_b(p, i)));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_flags_a"}, 64'({a_idle, a_read, a_write, a_done, a_b0_ce, a_b0_we, a_b1_ce, a_b1_we}), 64'h80);
        check_eq({tag, "_flags_b"}, 64'({b_idle, b_read, b_write, b_done, b_b0_ce, b_b0_we, b_b1_ce, b_b1_we}), 64'h80);
        check_eq({tag, "_bus_b"}, 64'({b_b0_addr, b_b1_addr, b_b1_d}), 64'd0);
    endtask

    task automatic run_4x4_full(input string tag, input int p, input bit pulse_read);
        int dc;
        load(p);
        run_once(1'b1, pulse_read, dc);
        check_eq({tag, "_done_cycle"}, 64'(dc), 64'd61);
        check_eq({tag, "_reads"}, 64'(b_rd), 64'd36);
        check_eq({tag, "_writes"}, 64'(b_wr), 64'd16);
        check_eq({tag, "_bad_addr"}, 64'(b_bad), 64'd0);
        check_img_b(tag, p);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, d1, d2, entries, rd0, wr0;
        bit prev;
        rst_n = 1'b0; run_a = 1'b0; run_b = 1'b0; clr = 1'b0; pat = 0;
        n_checks = 0; n_fail = 0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        load(0);
        run_once(1'b0, 1'b0, dc);
        check_eq("t1_done_cycle", 64'(dc), 64'd21);
        check_eq("t1_reads", 64'(a_rd), 64'd9);
        check_eq("t1_writes", 64'(a_wr), 64'd9);
        check_eq("t1_bad_addr", 64'(a_bad), 64'd0);
        check_img_a("t1", 0);
        @(negedge clk);
        check_eq("t1_idle_after_done", 64'(a_idle), 64'd1);

        load(1);
        run_once(1'b0, 1'b0, dc);
        check_eq("t2_done_cycle", 64'(dc), 64'd21);
        check_img_a("t2", 1);

        run_4x4_full("t3", 2, 1'b0);
        run_4x4_full("t4", 2, 1'b1);
        run_4x4_full("t7", 3, 1'b0);

        load(2);
        @(negedge clk); run_b = 1'b1;
        @(negedge clk); run_b = 1'b0;
        entries = 0;
        prev = 1'b0;
        for (int cyc = 0; cyc < 200 && entries < 2; cyc++) begin
            if (b_read && !prev) entries++;
            prev = b_read;
            if (entries < 2) @(negedge clk);
        end
        check_eq("t5_reached_read2", 64'(entries), 64'd2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t5_async");
        rd0 = b_rd;
        wr0 = b_wr;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("t5_no_reads_after_rst", 64'(b_rd), 64'(rd0));
        check_eq("t5_no_writes_after_rst", 64'(b_wr), 64'(wr0));
        check_eq("t5_idle_after_rst", 64'(b_idle), 64'd1);
        run_4x4_full("t5_rerun", 2, 1'b0);

        load(2);
        @(negedge clk); run_b = 1'b1;
        d1 = -1;
        d2 = -1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            if (b_done && d1 < 0) d1 = cyc;
            else if (b_done) begin
                d2 = cyc;
                run_b = 1'b0;
                break;
            end
            if (d1 > 0 && cyc == d1 + 1) check_eq("t6_idle_gap", 64'(b_idle), 64'd1);
            if (d1 > 0 && cyc == d1 + 2) check_eq("t6_restart_write", 64'(b_write), 64'd1);
        end
        run_b = 1'b0;
        check_eq("t6_done1_cycle", 64'(d1), 64'd61);
        check_eq("t6_done2_cycle", 64'(d2), 64'd123);
        check_eq("t6_reads", 64'(b_rd), 64'd72);
        check_eq("t6_writes", 64'(b_wr), 64'd32);
        check_img_b("t6", 2);

        repeat (2) @(negedge clk);
        check_eq("bus_invariants", 64'(inv_bad), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
